// File: rtl/systolic_tile_sequencer.sv
// Tile sequencer for the systolic array: walks the output-tile grid (tm inner, tn outer),
// clearing accumulators, streaming skewed operand reads, draining, and handing off each tile.
module systolic_tile_sequencer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PE_ROWS    = 4,
    parameter int unsigned PE_COLS    = 4,
    parameter int unsigned K_W        = 8,
    parameter int unsigned T_W        = 6,
    parameter int unsigned ADDR_W     = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [K_W-1:0]     cfg_k,
    input  logic [T_W-1:0]     cfg_tiles_n,
    input  logic [T_W-1:0]     cfg_tiles_m,
    input  logic               feed_stall,
    input  logic               wb_ready,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               acc_clear,
    output logic               a_rd_en,
    output logic               b_rd_en,
    output logic [ADDR_W-1:0]  a_rd_addr,
    output logic [ADDR_W-1:0]  b_rd_addr,
    output logic [PE_ROWS-1:0] a_lane_valid,
    output logic [PE_COLS-1:0] b_lane_valid,
    output logic               wb_valid,
    output logic [T_W-1:0]     wb_tile_n,
    output logic [T_W-1:0]     wb_tile_m,
    output logic [31:0]        cyc_busy,
    output logic [31:0]        cyc_stall
);

    // Skew depth and drain length of the array.
    localparam int unsigned S  = (PE_ROWS > PE_COLS) ? PE_ROWS : PE_COLS;
    localparam int unsigned D  = PE_ROWS + PE_COLS - 1;
    // Counter is shared by FEED (up to K+S-1) and DRAIN (up to D-1).
    localparam int unsigned CW = K_W + $clog2(S + D) + 1;

    if (DATA_WIDTH == 0 || PE_ROWS == 0 || PE_COLS == 0) begin : g_bad_cfg
        $error("systolic_tile_sequencer: zero-sized array or operand width");
    end

    typedef enum logic [2:0] {StIdle, StClear, StFeed, StDrain, StWb, StDone} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic              stall_q;
    logic [K_W-1:0]    k_q;
    logic [T_W-1:0]    tiles_n_q, tiles_m_q;
    logic [T_W-1:0]    tn_q, tm_q;
    logic [ADDR_W-1:0] a_base_q, b_base_q;
    logic              err_q;
    logic [31:0]       cyc_busy_q, cyc_stall_q;

    logic [CW-1:0]     feed_last;
    logic              last_tm, last_tn, cfg_zero, feeding, rd;

    assign feed_last = CW'(k_q) + CW'(S - 1);
    assign last_tm   = (tm_q == tiles_m_q - T_W'(1));
    assign last_tn   = (tn_q == tiles_n_q - T_W'(1));
    assign cfg_zero  = (cfg_k == '0) || (cfg_tiles_n == '0) || (cfg_tiles_m == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a stall cycle never ends FEED, so every feed slot is shown once.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = cfg_zero ? StDone : StClear;
            StClear: state_d = StFeed;
            StFeed:  if (!stall_q && cnt_q == feed_last) state_d = StDrain;
            StDrain: if (cnt_q == CW'(D - 1)) state_d = StWb;
            StWb:    if (wb_ready) state_d = (last_tm && last_tn) ? StDone : StClear;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Job config, tile walk and feed/drain counter.
    // A stall sampled at an edge advances past the current slot and then freezes the counter
    // for the stall cycles that follow, so no slot is issued twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            stall_q   <= 1'b0;
            k_q       <= '0;
            tiles_n_q <= '0;
            tiles_m_q <= '0;
            tn_q      <= '0;
            tm_q      <= '0;
            a_base_q  <= '0;
            b_base_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        k_q       <= cfg_k;
                        tiles_n_q <= cfg_tiles_n;
                        tiles_m_q <= cfg_tiles_m;
                        tn_q      <= '0;
                        tm_q      <= '0;
                        a_base_q  <= '0;
                        b_base_q  <= '0;
                        err_q     <= cfg_zero;
                        cnt_q     <= '0;
                        stall_q   <= 1'b0;
                    end
                end
                StClear: begin
                    cnt_q   <= '0;
                    stall_q <= 1'b0;
                end
                StFeed: begin
                    if (!stall_q && cnt_q == feed_last) begin
                        cnt_q   <= '0;
                        stall_q <= 1'b0;
                    end else begin
                        stall_q <= feed_stall;
                        if (!stall_q) cnt_q <= cnt_q + CW'(1);
                    end
                end
                StDrain: cnt_q <= cnt_q + CW'(1);
                StWb: begin
                    if (wb_ready) begin
                        if (!last_tm) begin
                            tm_q     <= tm_q + T_W'(1);
                            b_base_q <= b_base_q + ADDR_W'(k_q);
                        end else if (!last_tn) begin
                            tm_q     <= '0;
                            b_base_q <= '0;
                            tn_q     <= tn_q + T_W'(1);
                            a_base_q <= a_base_q + ADDR_W'(k_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating busy/stall counters; cleared on an accepted start, held while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_busy_q  <= '0;
            cyc_stall_q <= '0;
        end else if (state_q == StIdle) begin
            if (start) begin
                cyc_busy_q  <= '0;
                cyc_stall_q <= '0;
            end
        end else begin
            if (cyc_busy_q != '1) cyc_busy_q <= cyc_busy_q + 32'd1;
            if (state_q == StFeed && stall_q && cyc_stall_q != '1) begin
                cyc_stall_q <= cyc_stall_q + 32'd1;
            end
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        err       = done && err_q;
        acc_clear = (state_q == StClear);
        feeding   = (state_q == StFeed) && !stall_q;
        rd        = feeding && (cnt_q < CW'(k_q));
        a_rd_en   = rd;
        b_rd_en   = rd;
        a_rd_addr = rd ? a_base_q + ADDR_W'(cnt_q) : '0;
        b_rd_addr = rd ? b_base_q + ADDR_W'(cnt_q) : '0;
        for (int unsigned r = 0; r < PE_ROWS; r++) begin
            a_lane_valid[r] = feeding && (cnt_q >= CW'(r + 1)) && (cnt_q <= CW'(k_q) + CW'(r));
        end
        for (int unsigned j = 0; j < PE_COLS; j++) begin
            b_lane_valid[j] = feeding && (cnt_q >= CW'(j + 1)) && (cnt_q <= CW'(k_q) + CW'(j));
        end
        wb_valid  = (state_q == StWb);
        wb_tile_n = wb_valid ? tn_q : '0;
        wb_tile_m = wb_valid ? tm_q : '0;
        cyc_busy  = cyc_busy_q;
        cyc_stall = cyc_stall_q;
    end

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer: table of jobs plus random jobs, checked against a
// slot/tile-level model of the feed schedule, write-back order and job timing.
module tb_systolic_tile_sequencer;

    localparam int S = 4;  // max(PE_ROWS, PE_COLS)
    localparam int D = 7;  // PE_ROWS + PE_COLS - 1

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  cfg_k;
    logic [5:0]  cfg_tiles_n, cfg_tiles_m;
    logic        feed_stall, wb_ready;
    logic        busy, done, err, acc_clear, a_rd_en, b_rd_en, wb_valid;
    logic [11:0] a_rd_addr, b_rd_addr;
    logic [3:0]  a_lane_valid, b_lane_valid;
    logic [5:0]  wb_tile_n, wb_tile_m;
    logic [31:0] cyc_busy, cyc_stall;

    systolic_tile_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_k        (cfg_k),
        .cfg_tiles_n  (cfg_tiles_n),
        .cfg_tiles_m  (cfg_tiles_m),
        .feed_stall   (feed_stall),
        .wb_ready     (wb_ready),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .acc_clear    (acc_clear),
        .a_rd_en      (a_rd_en),
        .b_rd_en      (b_rd_en),
        .a_rd_addr    (a_rd_addr),
        .b_rd_addr    (b_rd_addr),
        .a_lane_valid (a_lane_valid),
        .b_lane_valid (b_lane_valid),
        .wb_valid     (wb_valid),
        .wb_tile_n    (wb_tile_n),
        .wb_tile_m    (wb_tile_m),
        .cyc_busy     (cyc_busy),
        .cyc_stall    (cyc_stall)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int k, tn, tm, sp, sl, ww;
        bit poke;
        int exp_done, exp_stall, exp_clears;
        bit exp_err;
    } vec_t;

    vec_t vecs[12];

    // Per-job observations.
    int          r_done_cyc, r_clears, r_clear_cyc, r_first_rd, r_last_rd;
    int          r_first_v3, r_last_v3, r_wb_cyc, r_rd_cnt, r_trace_bad, r_wb_bad, r_wb_cnt;
    bit          r_done_seen;
    logic        r_err, r_after;
    logic [31:0] r_busy, r_stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic bit any_out();
        return ((|{busy, done, err, acc_clear, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr,
                   a_lane_valid, b_lane_valid, wb_valid, wb_tile_n, wb_tile_m,
                   cyc_busy, cyc_stall}) !== 1'b0);
    endfunction

    // Runs one job. sp<0 means no stall; otherwise each tile stalls sl cycles after feed slot sp.
    // ww = cycles wb_ready is held low per tile. poke = pulse start during the first FEED.
    task automatic run_job(input int k, input int tn, input int tm, input int sp, input int sl,
                           input int ww, input bit poke);
        int cyc, t_clear, o, c, wb_left;
        bit in_wb;
        logic exp_rd;
        logic [3:0] exp_v;
        logic [11:0] exp_a, exp_b;
        logic [5:0] hold_n, hold_m;
        r_done_cyc = -1; r_done_seen = 0; r_err = 1'b0; r_clears = 0; r_clear_cyc = -1;
        r_first_rd = -1; r_last_rd = -1; r_first_v3 = -1; r_last_v3 = -1; r_wb_cyc = -1;
        r_rd_cnt = 0; r_trace_bad = 0; r_wb_bad = 0; r_wb_cnt = 0;
        @(negedge clk);
        cfg_k = 8'(k); cfg_tiles_n = 6'(tn); cfg_tiles_m = 6'(tm);
        start = 1'b1; feed_stall = 1'b0; wb_ready = 1'b1;
        cyc = 0; t_clear = 0; wb_left = 0; in_wb = 0; hold_n = '0; hold_m = '0;
        while (!r_done_seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (acc_clear) begin
                r_clears++;
                t_clear = cyc;
                if (r_clear_cyc < 0) r_clear_cyc = cyc;
            end
            if (done) begin
                r_done_seen = 1;
                r_done_cyc  = cyc;
                r_err       = err;
            end
            // Feed slot for this cycle: offset from CLEAR, minus stall cycles already taken.
            o = cyc - t_clear - 1;
            c = o;
            if (sp >= 0 && o > sp) c = (o <= sp + sl) ? -1 : o - sl;
            exp_rd = 1'b0; exp_v = '0; exp_a = '0; exp_b = '0;
            if (r_clears > 0 && c >= 0 && c < k + S) begin
                exp_rd = (c < k);
                exp_a  = 12'(((r_clears - 1) / tm) * k + c);
                exp_b  = 12'(((r_clears - 1) % tm) * k + c);
                for (int r = 0; r < 4; r++) exp_v[r] = (c >= r + 1) && (c <= r + k);
            end
            if (a_rd_en !== exp_rd || b_rd_en !== exp_rd || a_lane_valid !== exp_v ||
                b_lane_valid !== exp_v) begin
                r_trace_bad++;
            end else if (exp_rd && (a_rd_addr !== exp_a || b_rd_addr !== exp_b)) begin
                r_trace_bad++;
            end
            if (a_rd_en === 1'b1) begin
                r_rd_cnt++;
                if (r_first_rd < 0) r_first_rd = cyc;
                r_last_rd = cyc;
            end
            if (a_lane_valid[3] === 1'b1) begin
                if (r_first_v3 < 0) r_first_v3 = cyc;
                r_last_v3 = cyc;
            end
            if (wb_valid === 1'b1) begin
                if (!in_wb) begin
                    in_wb = 1; wb_left = ww; hold_n = wb_tile_n; hold_m = wb_tile_m;
                    if (r_wb_cyc < 0) r_wb_cyc = cyc;
                    if (wb_tile_n !== 6'(r_wb_cnt / tm) || wb_tile_m !== 6'(r_wb_cnt % tm))
                        r_wb_bad++;
                end else if (wb_tile_n !== hold_n || wb_tile_m !== hold_m) begin
                    r_wb_bad++;
                end
                if (wb_left > 0) begin
                    wb_ready = 1'b0;
                    wb_left--;
                end else begin
                    wb_ready = 1'b1;
                    in_wb = 0;
                    r_wb_cnt++;
                end
            end else begin
                wb_ready = 1'b1;
            end
            feed_stall = (r_clears > 0 && sp >= 0 && o >= sp && o < sp + sl);
            if (poke && r_clears == 1 && o == 3) begin
                start = 1'b1;
                cfg_tiles_n = 6'd3;
            end
        end
        feed_stall = 1'b0;
        wb_ready = 1'b1;
        start = 1'b0;
        @(negedge clk);
        r_busy  = cyc_busy;
        r_stall = cyc_stall;
        r_after = busy | done;
    endtask

    task automatic job_checks(input string tag, input int k, input int tiles, input int exp_done,
                              input bit exp_err, input int exp_clears, input int exp_stall);
        check({tag, "/done_cycle"}, r_done_cyc, exp_done);
        check({tag, "/err"}, r_err, exp_err);
        check({tag, "/acc_clears"}, r_clears, exp_clears);
        check({tag, "/cyc_busy"}, r_busy, exp_done);
        check({tag, "/cyc_stall"}, r_stall, exp_stall);
        check({tag, "/feed_trace_errs"}, r_trace_bad, 0);
        check({tag, "/wb_order_errs"}, r_wb_bad, 0);
        check({tag, "/wb_count"}, r_wb_cnt, exp_err ? 0 : tiles);
        check({tag, "/rd_count"}, r_rd_cnt, exp_err ? 0 : tiles * k);
        check({tag, "/idle_after_done"}, r_after, 0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_bad, k, tn, tm, sp, sl, ww, per;
        rst_n = 1'b0; start = 1'b0; cfg_k = '0; cfg_tiles_n = '0; cfg_tiles_m = '0;
        feed_stall = 1'b0; wb_ready = 1'b0;

        // {k, tn, tm, stall_pos, stall_len, wb_wait, poke, done_cycle, cyc_stall, clears, err}
        vecs[0]  = '{8,   1, 1, -1, 0, 0, 1'b0, 22,  0, 1, 1'b0};
        vecs[1]  = '{4,   2, 2, -1, 0, 0, 1'b0, 69,  0, 4, 1'b0};
        vecs[2]  = '{8,   1, 1,  4, 3, 0, 1'b0, 25,  3, 1, 1'b0};
        vecs[3]  = '{8,   1, 1, -1, 0, 5, 1'b0, 27,  0, 1, 1'b0};
        vecs[4]  = '{0,   1, 1, -1, 0, 0, 1'b0, 1,   0, 0, 1'b1};
        vecs[5]  = '{4,   0, 2, -1, 0, 0, 1'b0, 1,   0, 0, 1'b1};
        vecs[6]  = '{4,   2, 0, -1, 0, 0, 1'b0, 1,   0, 0, 1'b1};
        vecs[7]  = '{1,   1, 3, -1, 0, 0, 1'b0, 43,  0, 3, 1'b0};
        vecs[8]  = '{4,   1, 1, -1, 0, 0, 1'b1, 18,  0, 1, 1'b0};
        vecs[9]  = '{255, 1, 1, -1, 0, 0, 1'b0, 269, 0, 1, 1'b0};
        vecs[10] = '{3,   1, 2,  0, 2, 1, 1'b0, 39,  4, 2, 1'b0};
        vecs[11] = '{2,   1, 1,  4, 2, 0, 1'b0, 18,  2, 1, 1'b0};

        #1;
        check("reset_outputs_zero", any_out(), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (any_out()) idle_bad++;
        end
        check("idle_after_reset_outputs_zero", idle_bad, 0);
        wb_ready = 1'b1;

        foreach (vecs[i]) begin
            run_job(vecs[i].k, vecs[i].tn, vecs[i].tm, vecs[i].sp, vecs[i].sl, vecs[i].ww,
                    vecs[i].poke);
            job_checks($sformatf("vec%0d", i), vecs[i].k, vecs[i].tn * vecs[i].tm,
                       vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_clears, vecs[i].exp_stall);
            if (i == 0) begin
                check("single/clear_cycle", r_clear_cyc, 1);
                check("single/first_rd_cycle", r_first_rd, 2);
                check("single/last_rd_cycle", r_last_rd, 9);
                check("single/first_lane3_cycle", r_first_v3, 6);
                check("single/last_lane3_cycle", r_last_v3, 13);
                check("single/wb_cycle", r_wb_cyc, 21);
            end
        end

        // Reset in the middle of DRAIN, then a clean job from zero bases.
        @(negedge clk);
        cfg_k = 8'd8; cfg_tiles_n = 6'd2; cfg_tiles_m = 6'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        check("mid_drain/busy_before_reset", busy, 1);
        #2 rst_n = 1'b0;
        #1 check("mid_drain/outputs_zero_in_reset", any_out(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_drain/idle_after_release", any_out(), 0);
        run_job(8, 1, 1, -1, 0, 0, 1'b0);
        job_checks("after_reset", 8, 1, 22, 1'b0, 1, 0);

        // Random jobs against the model.
        for (int n = 0; n < 6; n++) begin
            k  = int'($urandom_range(1, 10));
            tn = int'($urandom_range(1, 3));
            tm = int'($urandom_range(1, 3));
            sp = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, k + S - 2));
            sl = int'($urandom_range(1, 4));
            ww = int'($urandom_range(0, 3));
            per = k + S + D + 2 + ((sp >= 0) ? sl : 0) + ww;
            run_job(k, tn, tm, sp, sl, ww, 1'b0);
            job_checks($sformatf("rand%0d", n), k, tn * tm, tn * tm * per + 1, 1'b0, tn * tm,
                       (sp >= 0) ? tn * tm * sl : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
